// File: rtl/arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arbiter                                                      |
// | Description : Round-robin arbiter, NUM requesters, registered one-hot gnt. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module arbiter #(
    parameter int NUM = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [NUM-1:0] req,
    output logic [NUM-1:0] gnt
);

    localparam int c_PTR_W = (NUM > 1) ? $clog2(NUM) : 1;

    logic [NUM-1:0]     r_gnt;
    logic [c_PTR_W-1:0] r_ptr;

    logic               w_found;
    logic [c_PTR_W-1:0] w_win;
    logic [c_PTR_W-1:0] w_idx;
    logic [c_PTR_W:0]   w_sum;
    logic [c_PTR_W-1:0] w_ptr_nxt;

    // Scan from r_ptr upward with modulo-NUM wrap; first active request wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM; i++) begin
            w_sum = {1'b0, r_ptr} + (c_PTR_W+1)'(i);
            if (w_sum >= (c_PTR_W+1)'(NUM)) begin
                w_idx = c_PTR_W'(w_sum - (c_PTR_W+1)'(NUM));
            end else begin
                w_idx = c_PTR_W'(w_sum);
            end
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_ptr_nxt = (w_win == c_PTR_W'(NUM - 1)) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gnt <= '0;
            r_ptr <= '0;
        end else if (w_found) begin
            r_gnt <= NUM'(1) << w_win;
            r_ptr <= w_ptr_nxt;
        end else begin
            r_gnt <= '0;
        end
    end

    assign gnt = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_arbiter                                                   |
// | Description : Directed and randomised self-checking bench for arbiter.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_arbiter;

    localparam int NUM = 4;

    logic           clk;
    logic           reset_n;
    logic [NUM-1:0] req;
    logic [NUM-1:0] gnt;

    int n_checks = 0;
    int n_errors = 0;

    arbiter #(.NUM(NUM)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply req, take one rising edge, sample 1 time unit later.
    task automatic step(input logic [NUM-1:0] r, input logic [NUM-1:0] exp, input string tag);
        req = r;
        @(posedge clk);
        #1;
        check(tag, 32'(gnt), 32'(exp));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    logic [NUM-1:0] rot_req [8] = '{4'b0110, 4'b1011, 4'b1111, 4'b0011,
                                    4'b1100, 4'b0000, 4'b1001, 4'b0100};
    logic [NUM-1:0] rot_gnt [8] = '{4'b0010, 4'b1000, 4'b0001, 4'b0010,
                                    4'b0100, 4'b0000, 4'b1000, 4'b0100};
    logic [NUM-1:0] full_gnt [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    int             m_ptr;
    int             waitc [NUM];
    logic [NUM-1:0] m_exp;
    logic           m_rst;
    logic           starve;

    initial begin
        reset_n = 1'b1;
        req     = '0;
        #3;

        // Reset held with everyone requesting
        reset_n = 1'b0;
        req     = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", 32'(gnt), 32'h0);
        end
        reset_n = 1'b1;

        // Rotation sequence from reset
        for (int i = 0; i < 8; i++) step(rot_req[i], rot_gnt[i], "rotation");

        // Full load
        do_reset();
        for (int i = 0; i < 8; i++) step(4'b1111, full_gnt[i % 4], "full_load");

        // Single requester, then a second joins
        for (int i = 0; i < 3; i++) step(4'b0100, 4'b0100, "single");
        step(4'b0101, 4'b0001, "single_join0");
        step(4'b0101, 4'b0100, "single_join1");

        // Idle keeps the pointer
        do_reset();
        step(4'b0010, 4'b0010, "idle_pre");
        step(4'b0000, 4'b0000, "idle0");
        step(4'b0000, 4'b0000, "idle1");
        step(4'b0011, 4'b0001, "idle_wrap");

        // Asynchronous reset between edges, then priority back at index 0
        step(4'b1111, 4'b0010, "async_pre");
        #2;
        reset_n = 1'b0;
        #1;
        check("async_clear", 32'(gnt), 32'h0);
        #1;
        reset_n = 1'b1;
        step(4'b1110, 4'b0010, "post_reset1");
        req = '0;
        #3;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        step(4'b1111, 4'b0001, "post_reset0");

        // Randomised run against an independent reference model
        do_reset();
        m_ptr = 0;
        for (int j = 0; j < NUM; j++) waitc[j] = 0;
        for (int n = 0; n < 10000; n++) begin
            m_rst   = ($urandom_range(0, 99) == 0);
            reset_n = ~m_rst;
            req     = NUM'($urandom);
            @(posedge clk);
            #1;
            m_exp = '0;
            if (m_rst) begin
                m_ptr = 0;
            end else begin
                for (int k = 0; k < NUM; k++) begin
                    if (m_exp == '0 && req[(m_ptr + k) % NUM]) begin
                        m_exp[(m_ptr + k) % NUM] = 1'b1;
                        m_ptr = (m_ptr + k + 1) % NUM;
                    end
                end
            end
            starve = 1'b0;
            for (int j = 0; j < NUM; j++) begin
                if (m_rst || !req[j] || gnt[j]) waitc[j] = 0;
                else waitc[j]++;
                if (waitc[j] >= NUM) starve = 1'b1;
            end
            check("rand_model", 32'(gnt), 32'(m_exp));
            check("rand_onehot0", 32'($onehot0(gnt)), 32'h1);
            check("rand_sampled", 32'(gnt & ~req), 32'h0);
            check("rand_starve", 32'(starve), 32'h0);
            #1;
            reset_n = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
